booth_seq_mult_ctrl: RTL and testbench



---
 rtl/booth_seq_mult_ctrl_pkg.sv | 27 ++
 rtl/booth_seq_mult_ctrl_if.sv | 21 ++
 rtl/booth_seq_mult_ctrl_step.sv | 33 +++
 rtl/booth_seq_mult_ctrl.sv | 93 +++++++++
 tb/tb_booth_seq_mult_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/booth_seq_mult_ctrl_pkg.sv
// rtl/booth_seq_mult_ctrl_pkg.sv - shared FSM state and Booth op encodings
package booth_seq_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 recoding of the multiplier bit pair {Q0, Q(-1)}
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        booth_op_t op;
        case ({q0, q_m1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_mult_ctrl_if.sv
// rtl/booth_seq_mult_ctrl_if.sv - start/busy/done handshake and operand/product bus
interface booth_seq_mult_ctrl_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_mult_ctrl_step.sv
// rtl/booth_seq_mult_ctrl_step.sv - one combinational Booth add/sub plus arithmetic shift
module booth_step
    import booth_seq_mult_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N:0]   m,
    output logic [N:0]   a_next,
    output logic [N-1:0] q_next,
    output logic         q_m1_next
);
    booth_op_t  op;
    logic [N:0] sum;

    always_comb begin
        op  = booth_decode(q[0], q_m1);
        sum = a;
        case (op)
            BOOTH_ADD: sum = a + m;
            BOOTH_SUB: sum = a - m;
            default:   sum = a;
        endcase
    end

    // Shift {sum, q, q_m1} right by one, replicating the sign of sum
    assign a_next    = {sum[N], sum[N:1]};
    assign q_next    = {sum[0], q[N-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// rtl/booth_seq_mult_ctrl.sv - sequential radix-2 Booth multiplier controller
module booth_seq_mult_ctrl
    import booth_seq_mult_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_seq_mult_ctrl_if.slave bus
);
    localparam int CW = $clog2(N);

    state_t          state, state_next;
    logic [N:0]      a_q, m_q, a_nx;
    logic [N-1:0]    q_q, q_nx;
    logic            qm1_q, qm1_nx;
    logic [CW-1:0]   count_q;
    logic [2*N-1:0]  product_q;
    logic            last_iter;
    logic            busy_c, done_c;

    booth_step #(.N(N)) u_step (
        .a         (a_q),
        .q         (q_q),
        .q_m1      (qm1_q),
        .m         (m_q),
        .a_next    (a_nx),
        .q_next    (q_nx),
        .q_m1_next (qm1_nx)
    );

    assign last_iter = (count_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_CALC;
            ST_CALC: begin
                busy_c = 1'b1;
                if (last_iter) state_next = ST_DONE;
            end
            ST_DONE: begin
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands are captured only on the accepting edge; later bus changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        m_q     <= {bus.multiplicand[N-1], bus.multiplicand};
                        q_q     <= bus.multiplier;
                        a_q     <= '0;
                        qm1_q   <= 1'b0;
                        count_q <= '0;
                    end
                end
                ST_CALC: begin
                    a_q     <= a_nx;
                    q_q     <= q_nx;
                    qm1_q   <= qm1_nx;
                    count_q <= count_q + CW'(1);
                    if (last_iter) product_q <= {a_nx[N-1:0], q_nx};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// tb/tb_booth_seq_mult_ctrl.sv - directed and random checks against an arithmetic product model
module tb_booth_seq_mult_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [N-1:0] ha [0:63];
    logic [N-1:0] hb [0:63];

    booth_seq_mult_ctrl_if #(.N(N)) bus ();

    booth_seq_mult_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p[2*N-1:0];
    endfunction

    task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2*N-1:0] exp);
        int busy_n = 0;
        int done_n = 0;
        int done_at = -1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.multiplicand = N'($urandom);
        bus.multiplier   = N'($urandom);
        for (int t = 0; t < N + 4; t++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = t;
            end
            if (bus.busy && bus.done) chk({tag, "_busy_and_done"}, 64'(1), 64'(0));
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(N));
        chk({tag, "_done_count"}, 64'(done_n), 64'(1));
        chk({tag, "_done_latency"}, 64'(done_at), 64'(N));
        chk({tag, "_product"}, 64'(bus.product), 64'(exp));
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_product", 64'(bus.product), 64'(0));

        run_mul("3x5", 8'd3, 8'd5, 16'h000F);
        tick();
        chk("3x5_held", 64'(bus.product), 64'(16'h000F));
        run_mul("m3x7", 8'hFD, 8'h07, 16'hFFEB);
        run_mul("0x9c", 8'h00, 8'h9C, 16'h0000);
        run_mul("m128xm128", 8'h80, 8'h80, 16'h4000);
        run_mul("127xm128", 8'h7F, 8'h80, 16'hC080);
        run_mul("m1xm1", 8'hFF, 8'hFF, 16'h0001);

        for (int i = 0; i < 16; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            run_mul("rand", ra, rb, ref_mul(ra, rb));
        end

        // start held high with operands changing every cycle
        for (int t = 0; t < 3 * (N + 2); t++) begin
            ha[t] = N'($urandom);
            hb[t] = N'($urandom);
            bus.multiplicand = ha[t];
            bus.multiplier   = hb[t];
            bus.start        = 1'b1;
            tick();
            chk("held_done", 64'(bus.done), 64'((t % (N + 2)) == N));
            if ((t % (N + 2)) == N)
                chk("held_product", 64'(bus.product), 64'(ref_mul(ha[t-N], hb[t-N])));
        end
        bus.start = 1'b0;

        // reset during the 4th CALC cycle aborts the operation
        bus.multiplicand = 8'd3;
        bus.multiplier   = 8'd5;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_before", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_product", 64'(bus.product), 64'(0));
        for (int t = 0; t < N + 2; t++) begin
            tick();
            chk("abort_no_done", 64'(bus.done), 64'(0));
        end
        run_mul("6xm2", 8'd6, 8'hFE, 16'hFFF4);

        // reset coincident with start wins
        rst              = 1'b1;
        bus.start        = 1'b1;
        bus.multiplicand = 8'd9;
        bus.multiplier   = 8'd9;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", 64'(bus.busy), 64'(0));
        chk("rst_start_product", 64'(bus.product), 64'(0));
        tick();
        chk("rst_start_still_idle", 64'(bus.busy), 64'(0));
        run_mul("5xm7", 8'd5, 8'hF9, 16'hFFDD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
